iic_slave_bit_shift: RTL and testbench
======================================

// Module: iic_slave_bit_shift
// PURPOSE
//  I2C target (slave) byte engine; sits on the bus opposite our I2C master bit-shift engine.
//  Oversamples SCL/SDA with clk, detects START/STOP, matches a 7-bit address.
//  Receives write bytes to user logic, serves read bytes from user logic. Drives SDA open-drain only (low or Z).
//  Never drives SCL (no clock stretching).
// PARAMETERS
//  SLAVE_ADDR  7'h50  7-bit bus address this target answers to
//  FILTER_LEN  3      clk cycles a synced SCL/SDA level must hold before it is accepted (glitch filter)
// PORTS
//  clk        in     1  system clock; must be >= 20x SCL frequency
//  rst_n      in     1  asynchronous, active-low reset
//  iic_clk    in     1  bus SCL
//  iic_sda    inout  1  bus SDA, open-drain: 0 or 1'bz
//  rx_ack_en  in     1  1 = ACK received write bytes, 0 = NACK them
//  rx_data    out    8  last received write byte, MSB first on bus
//  rx_valid   out    1  1-clk pulse: new byte in rx_data
//  tx_data    in     8  next read byte; must be stable from tx_req until next SCL fall
//  tx_req     out    1  1-clk pulse: load tx_data for the coming read byte
//  ack_o      out    1  master's ACK bit after each read byte (0 = ACK, 1 = NACK)
//  rw_o       out    1  R/W bit of the last matched address byte
//  busy       out    1  high from START to STOP, or until address mismatch / NACK release
//  stop_det   out    1  1-clk pulse on STOP detect
// BEHAVIOUR
//  Reset: all outputs 0, SDA released (Z), state IDLE, bit counter 0.
//   Takes effect immediately, including mid-byte.
//  Input path: 2-FF sync, then FILTER_LEN stable-count filter per line.
//   Edges are detected from the filtered values.
//   Edge-to-action latency is 2+FILTER_LEN+1 clk.
//  START = filtered SDA 1->0 while SCL=1.
//   Accepted in every state, including repeated START.
//   Effect: clear counter, release SDA, go to ADDR, busy=1.
//  STOP = filtered SDA 0->1 while SCL=1.
//   Accepted in every state.
//   Effect: release SDA, go to IDLE, busy=0, stop_det pulse.
//  Sample on SCL rise; change SDA only on SCL fall. START/STOP take priority over a same-cycle SCL edge.
//  States:
//   IDLE     wait for START; SDA released
//   ADDR     shift 8 bits on SCL rises
//            after the 8th: if [7:1]==SLAVE_ADDR, set rw_o=[0] and go to ADDR_ACK
//            if rw_o=1, pulse tx_req
//            on mismatch go to IGNORE
//   ADDR_ACK next SCL fall drives SDA low; the following fall releases it
//            on that release fall: if rw_o=0 go to WR_DATA
//            if rw_o=1 load tx_data, drive bit7 and go to RD_DATA
//   WR_DATA  shift 8 bits on SCL rises; after the 8th, update rx_data
//            pulse rx_valid in the next clk, go to WR_ACK
//   WR_ACK   next fall: drive low if rx_ack_en (sampled then), else stay Z
//            following fall: release, go to WR_DATA
//   RD_DATA  on each SCL fall, drive next bit (1 = Z, 0 = low)
//            after the 8th bit's fall-out, release SDA and go to RD_ACK
//   RD_ACK   on SCL rise, ack_o <= SDA
//            if 0: pulse tx_req; on next fall load tx_data, drive bit7, go to RD_DATA
//            if 1: go to IGNORE
//   IGNORE   SDA released; wait for START/STOP; busy=0
//  Bit counter 0..7, wraps to 0 entering each ACK state.
//  Unlimited bytes per transfer.
//  tx_data not updated after tx_req: the stale value is resent; no error flag.
//  Noise on SCL/SDA shorter than FILTER_LEN clk: no state change.
// TESTING
//  1. Write addr 0x50 W, bytes 0xA5, 0x3C, STOP.
//     -> SDA low in 3 ACK slots; rx_valid x2 with rx_data A5 then 3C; stop_det pulse; busy 0.
//  2. Write addr 0x51 W, one byte.
//     -> SDA never driven low; rx_valid never pulses; busy drops after 8th address bit.
//  3. Read addr 0x50 R, tx_data 0x96 then 0x0F; master ACKs byte 1, NACKs byte 2.
//     -> bus bits 10010110, 00001111; tx_req x2; ack_o 0 then 1; SDA released after byte 2.
//  4. Repeated START after 4 bits of a write byte, then addr 0x50 R.
//     -> no rx_valid; new address ACKed; rw_o=1; tx_req pulses.
//  5. Write 0x50 W, rx_ack_en=0, byte 0x11.
//     -> 9th slot SDA stays Z (NACK); rx_valid still pulses with 0x11.
//  6. SCL glitch of FILTER_LEN-1 clk mid-byte -> ignored, byte intact.
//     Assert rst_n low while driving a 0 bit -> SDA Z at once; outputs 0.

Source files
------------

// File: rtl/iic_slave_bit_shift.sv
// rtl/iic_slave_bit_shift.sv - I2C target byte engine with glitch-filtered SCL/SDA
//
// Ports:
//   clk, rst_n          system clock (>= 20x SCL), asynchronous active-low reset
//   iic_clk             bus SCL (input only, never stretched)
//   iic_sda             bus SDA, open-drain (driven 0 or released to Z)
//   rx_ack_en           1 = ACK received write bytes, 0 = NACK them
//   rx_data, rx_valid   last received write byte and its 1-clk strobe
//   tx_data, tx_req     next read byte and the 1-clk request to provide it
//   ack_o               master's ACK bit after each read byte (0 = ACK)
//   rw_o                R/W bit of the last matched address byte
//   busy                transfer in progress for this target
//   stop_det            1-clk pulse on STOP
module iic_slave_bit_shift #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iic_clk,
  inout  wire        iic_sda,
  input  logic       rx_ack_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       ack_o,
  output logic       rw_o,
  output logic       busy,
  output logic       stop_det
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  // Index 0 = SCL, index 1 = SDA.
  logic [1:0]    raw;
  logic [1:0]    sync1, sync2, filt, filt_d;
  logic [CW-1:0] fcnt [2];

  logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [6:0] shreg, shreg_n;
  logic       ack_ph, ack_ph_n;  // 0: waiting for first event of the ACK slot, 1: second
  logic       sda_oe, sda_oe_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n, tx_req_n, ack_o_n, rw_o_n, busy_n, stop_det_n;

  assign iic_sda = sda_oe ? 1'b0 : 1'bz;
  assign raw     = {iic_sda, iic_clk};

  // Sync then accept a new level only after it has persisted FILTER_LEN clk.
  // Lines idle high, so the filter resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      filt_d  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_rise = filt[0] & ~filt_d[0];
  assign scl_fall = ~filt[0] & filt_d[0];
  assign start_c  = filt_d[1] & ~filt[1] & scl_f;
  assign stop_c   = ~filt_d[1] & filt[1] & scl_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      ack_ph   <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      ack_o    <= 1'b0;
      rw_o     <= 1'b0;
      busy     <= 1'b0;
      stop_det <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      ack_ph   <= ack_ph_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      ack_o    <= ack_o_n;
      rw_o     <= rw_o_n;
      busy     <= busy_n;
      stop_det <= stop_det_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    ack_ph_n   = ack_ph;
    sda_oe_n   = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    ack_o_n    = ack_o;
    rw_o_n     = rw_o;
    busy_n     = busy;
    stop_det_n = 1'b0;

    // Bus conditions override any same-cycle SCL edge handling below.
    if (stop_c) begin
      state_n    = IDLE;
      bit_cnt_n  = '0;
      ack_ph_n   = 1'b0;
      sda_oe_n   = 1'b0;
      busy_n     = 1'b0;
      stop_det_n = 1'b1;
    end else if (start_c) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      ack_ph_n  = 1'b0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b1;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shreg_n = {shreg[5:0], sda_f};
            if (bit_cnt == 3'd7) begin
              bit_cnt_n = '0;
              // The seven earlier samples are the address; this one is R/W.
              if (shreg == SLAVE_ADDR) begin
                rw_o_n   = sda_f;
                tx_req_n = sda_f;
                ack_ph_n = 1'b0;
                state_n  = ADDR_ACK;
              end else begin
                busy_n  = 1'b0;
                state_n = IGNORE;
              end
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe_n = 1'b1;
              ack_ph_n = 1'b1;
            end else begin
              ack_ph_n = 1'b0;
              if (rw_o) begin
                shreg_n  = tx_data[6:0];
                sda_oe_n = ~tx_data[7];
                state_n  = RD_DATA;
              end else begin
                sda_oe_n = 1'b0;
                state_n  = WR_DATA;
              end
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shreg_n = {shreg[5:0], sda_f};
            if (bit_cnt == 3'd7) begin
              bit_cnt_n  = '0;
              rx_data_n  = {shreg, sda_f};
              rx_valid_n = 1'b1;
              ack_ph_n   = 1'b0;
              state_n    = WR_ACK;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe_n = rx_ack_en;
              ack_ph_n = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              ack_ph_n = 1'b0;
              state_n  = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          // bit7 is already on the bus; seven falls shift out the rest,
          // the eighth frees SDA for the master's ACK.
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              bit_cnt_n = '0;
              sda_oe_n  = 1'b0;
              ack_ph_n  = 1'b0;
              state_n   = RD_ACK;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
              sda_oe_n  = ~shreg[6];
              shreg_n   = {shreg[5:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (!ack_ph) begin
            if (scl_rise) begin
              ack_o_n = sda_f;
              if (!sda_f) begin
                tx_req_n = 1'b1;
                ack_ph_n = 1'b1;
              end else begin
                busy_n  = 1'b0;
                state_n = IGNORE;
              end
            end
          end else if (scl_fall) begin
            ack_ph_n = 1'b0;
            shreg_n  = tx_data[6:0];
            sda_oe_n = ~tx_data[7];
            state_n  = RD_DATA;
          end
        end
        IDLE, IGNORE: begin
          sda_oe_n = 1'b0;
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iic_slave_bit_shift.sv
// tb/tb_iic_slave_bit_shift.sv - directed bus-master bench for iic_slave_bit_shift
module tb_iic_slave_bit_shift;

  localparam int FL = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iic_clk = 1'b1;
  logic       m_sda = 1'b1;
  logic       rx_ack_en = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, ack_o, rw_o, busy, stop_det;
  wire        iic_sda;

  assign iic_sda = m_sda ? 1'bz : 1'b0;
  pullup (iic_sda);

  iic_slave_bit_shift #(.SLAVE_ADDR(7'h50), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .iic_clk(iic_clk), .iic_sda(iic_sda),
    .rx_ack_en(rx_ack_en), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .ack_o(ack_o), .rw_o(rw_o),
    .busy(busy), .stop_det(stop_det)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int rx_cnt = 0, txr_cnt = 0, stop_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_src[$];
  logic [7:0] rd_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare received bytes, feed read bytes on request.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rx_cnt++;
        if (rx_q.size() > 0) check("rx_data", {24'h0, rx_data}, {24'h0, rx_q.pop_front()});
      end
      if (tx_req) begin
        txr_cnt++;
        if (tx_src.size() > 0) tx_data = tx_src.pop_front();
      end
      if (stop_det) stop_cnt++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic qtr();
    repeat (10) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, input bit glitch, output logic s);
    m_sda = b;
    if (glitch) begin
      repeat (4) @(negedge clk);
      iic_clk = 1'b1;
      repeat (FL - 1) @(negedge clk);
      iic_clk = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      qtr();
    end
    iic_clk = 1'b1;
    qtr();
    s = iic_sda;
    qtr();
    iic_clk = 1'b0;
    qtr();
  endtask

  task automatic xfer_byte(input logic [7:0] d, input logic ack_in, input int gl_bit,
                           output logic [7:0] rd, output logic ack_s);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(d[i], (i == gl_bit), s);
      rd[i] = s;
    end
    xfer_bit(ack_in, 1'b0, ack_s);
  endtask

  task automatic bus_start();
    m_sda = 1'b1;
    qtr();
    iic_clk = 1'b1;
    qtr();
    m_sda = 1'b0;
    qtr();
    iic_clk = 1'b0;
    qtr();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    qtr();
    iic_clk = 1'b1;
    qtr();
    m_sda = 1'b1;
    qtr();
  endtask

  initial begin
    logic [7:0] rd;
    logic       a, s;
    logic [7:0] addr_w;
    int         r0, t0, s0;

    repeat (5) @(negedge clk);
    check("rst_sda", iic_sda, 1);
    check("rst_busy", busy, 0);
    check("rst_strobes", {rx_valid, tx_req, stop_det}, 0);
    check("rst_regs", {ack_o, rw_o, rx_data}, 0);
    rst_n = 1'b1;
    qtr();

    // 1: write two bytes
    r0 = rx_cnt; s0 = stop_cnt;
    bus_start();
    check("t1_busy_start", busy, 1);
    xfer_byte(8'hA0, 1'b1, -1, rd, a);
    check("t1_addr_ack", a, 0);
    check("t1_rw", rw_o, 0);
    rx_q.push_back(8'hA5);
    xfer_byte(8'hA5, 1'b1, -1, rd, a);
    check("t1_ack_a5", a, 0);
    rx_q.push_back(8'h3C);
    xfer_byte(8'h3C, 1'b1, -1, rd, a);
    check("t1_ack_3c", a, 0);
    bus_stop();
    qtr();
    check("t1_rx_cnt", rx_cnt - r0, 2);
    check("t1_rx_q", rx_q.size(), 0);
    check("t1_stop", stop_cnt - s0, 1);
    check("t1_busy_end", busy, 0);

    // 2: wrong address
    r0 = rx_cnt;
    bus_start();
    xfer_byte(8'hA2, 1'b1, -1, rd, a);
    check("t2_addr_nack", a, 1);
    check("t2_busy", busy, 0);
    xfer_byte(8'h77, 1'b1, -1, rd, a);
    check("t2_data_nack", a, 1);
    bus_stop();
    qtr();
    check("t2_rx_cnt", rx_cnt - r0, 0);

    // 3: read two bytes, ACK then NACK
    t0 = txr_cnt;
    tx_src.push_back(8'h96); rd_q.push_back(8'h96);
    tx_src.push_back(8'h0F); rd_q.push_back(8'h0F);
    bus_start();
    xfer_byte(8'hA1, 1'b1, -1, rd, a);
    check("t3_addr_ack", a, 0);
    check("t3_rw", rw_o, 1);
    check("t3_txreq1", txr_cnt - t0, 1);
    xfer_byte(8'hFF, 1'b0, -1, rd, a);
    check("t3_rd1", rd, rd_q.pop_front());
    check("t3_ack_o0", ack_o, 0);
    check("t3_txreq2", txr_cnt - t0, 2);
    xfer_byte(8'hFF, 1'b1, -1, rd, a);
    check("t3_rd2", rd, rd_q.pop_front());
    check("t3_ack_o1", ack_o, 1);
    check("t3_busy", busy, 0);
    check("t3_sda_rel", iic_sda, 1);
    bus_stop();
    qtr();
    check("t3_txreq_end", txr_cnt - t0, 2);

    // 4: repeated START after 4 data bits, then read
    r0 = rx_cnt; t0 = txr_cnt;
    tx_src.push_back(8'hC3); rd_q.push_back(8'hC3);
    bus_start();
    xfer_byte(8'hA0, 1'b1, -1, rd, a);
    check("t4_addr_w_ack", a, 0);
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, 1'b0, s);
    bus_start();
    xfer_byte(8'hA1, 1'b1, -1, rd, a);
    check("t4_addr_r_ack", a, 0);
    check("t4_rw", rw_o, 1);
    check("t4_txreq", txr_cnt - t0, 1);
    xfer_byte(8'hFF, 1'b1, -1, rd, a);
    check("t4_rd", rd, rd_q.pop_front());
    bus_stop();
    qtr();
    check("t4_rx_cnt", rx_cnt - r0, 0);

    // 5: NACK of write data
    r0 = rx_cnt;
    rx_ack_en = 1'b0;
    bus_start();
    xfer_byte(8'hA0, 1'b1, -1, rd, a);
    check("t5_addr_ack", a, 0);
    rx_q.push_back(8'h11);
    xfer_byte(8'h11, 1'b1, -1, rd, a);
    check("t5_data_nack", a, 1);
    bus_stop();
    qtr();
    check("t5_rx_cnt", rx_cnt - r0, 1);
    check("t5_rx_q", rx_q.size(), 0);
    rx_ack_en = 1'b1;

    // 6: SCL glitch mid-byte, then reset while ACK is driven low
    r0 = rx_cnt;
    bus_start();
    xfer_byte(8'hA0, 1'b1, -1, rd, a);
    rx_q.push_back(8'h5A);
    xfer_byte(8'h5A, 1'b1, 3, rd, a);
    check("t6_glitch_ack", a, 0);
    check("t6_rx_cnt", rx_cnt - r0, 1);
    bus_start();
    addr_w = 8'hA0;
    for (int i = 7; i >= 0; i--) xfer_bit(addr_w[i], 1'b0, s);
    m_sda = 1'b1;
    qtr();
    iic_clk = 1'b1;
    qtr();
    check("t6_ack_low", iic_sda, 0);
    rst_n = 1'b0;
    #2;
    check("t6_rst_sda", iic_sda, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rx_data", rx_data, 0);
    repeat (5) qtr();
    rst_n = 1'b1;
    qtr();
    check("t6_after_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
